stream_outstanding_limiter: RTL and testbench

//   Per-input stage placed directly upstream of one stream_arbiter input port.

---
 rtl/stream_outstanding_limiter.sv | 96 +++++++++
 tb/tb_stream_outstanding_limiter.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/stream_outstanding_limiter.sv
// Per-input stage ahead of an arbiter port: 2-entry registered FIFO that caps
// the number of requests in flight plus buffered at MAX_OUTST.
module stream_outstanding_limiter #(
  parameter type         DATA_T    = logic,
  parameter int unsigned MAX_OUTST = 4,
  parameter int unsigned CNT_W     = $clog2(MAX_OUTST + 1)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  DATA_T            inp_data_i,
  input  logic             inp_valid_i,
  output logic             inp_ready_o,
  output DATA_T            oup_data_o,
  output logic             oup_valid_o,
  input  logic             oup_ready_i,
  input  logic             rsp_done_i,
  output logic [CNT_W-1:0] outst_o,
  output logic             limit_o,
  output logic             err_o
);

  localparam int unsigned SUM_W = CNT_W + 1;
  localparam logic [SUM_W-1:0] MAX_S = SUM_W'(MAX_OUTST);

  if (MAX_OUTST == 0) begin : g_bad_max_outst
    $error("stream_outstanding_limiter: MAX_OUTST must be >= 1");
  end

  logic [1:0]       fill_q, fill_d;
  logic [CNT_W-1:0] outst_q, outst_d;
  logic             err_q, err_d;
  DATA_T            data_q [2];
  DATA_T            data_d [2];

  logic             in_hs, out_hs, rsp_ok, wr_slot0;
  logic [SUM_W-1:0] used;

  // Credits in use: issued-but-unretired plus still buffered here.
  assign used        = SUM_W'(outst_q) + SUM_W'(fill_q);
  assign inp_ready_o = (fill_q != 2'd2) && (used < MAX_S);
  assign limit_o     = (used == MAX_S);
  assign oup_valid_o = (fill_q != 2'd0);
  assign oup_data_o  = data_q[0];
  assign outst_o     = outst_q;
  assign err_o       = err_q;

  assign in_hs    = inp_valid_i && inp_ready_o;
  assign out_hs   = oup_valid_o && oup_ready_i;
  assign rsp_ok   = rsp_done_i && (outst_q != '0);
  assign wr_slot0 = (fill_q == 2'd0) || ((fill_q == 2'd1) && out_hs);

  // Slot 0 is always the head; a pop shifts slot 1 forward.
  always_comb begin
    data_d  = data_q;
    fill_d  = fill_q + 2'(in_hs) - 2'(out_hs);
    outst_d = outst_q + CNT_W'(out_hs) - CNT_W'(rsp_ok);
    err_d   = err_q || (rsp_done_i && (outst_q == '0));
    if (out_hs) begin
      data_d[0] = data_q[1];
    end
    if (in_hs) begin
      if (wr_slot0) begin
        data_d[0] = inp_data_i;
      end else begin
        data_d[1] = inp_data_i;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      fill_q  <= 2'd0;
      outst_q <= '0;
      err_q   <= 1'b0;
    end else begin
      fill_q  <= fill_d;
      outst_q <= outst_d;
      err_q   <= err_d;
    end
  end

  // Payload storage carries no reset; validity is tracked by fill_q.
  always_ff @(posedge clk_i) begin
    data_q <= data_d;
  end

  a_oup_data_stable: assert property (@(posedge clk_i) disable iff (rst_i)
    (oup_valid_o && !oup_ready_i) |=> $stable(oup_data_o));

  a_inp_data_stable: assert property (@(posedge clk_i) disable iff (rst_i)
    (inp_valid_i && !inp_ready_o) |=> $stable(inp_data_i));

  a_no_saturation: assert property (@(posedge clk_i) disable iff (rst_i)
    (used <= MAX_S));

endmodule

// File: tb/tb_stream_outstanding_limiter.sv
// Directed bench for stream_outstanding_limiter (MAX_OUTST=4, 8-bit payload):
// reset, streaming, credit limit, backpressure, simultaneous retire, underflow.
module tb_stream_outstanding_limiter;

  logic       clk_i = 1'b0;
  logic       rst_i;
  logic [7:0] inp_data_i;
  logic       inp_valid_i;
  logic       inp_ready_o;
  logic [7:0] oup_data_o;
  logic       oup_valid_o;
  logic       oup_ready_i;
  logic       rsp_done_i;
  logic [2:0] outst_o;
  logic       limit_o;
  logic       err_o;

  stream_outstanding_limiter #(
    .DATA_T   (logic [7:0]),
    .MAX_OUTST(4)
  ) dut (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .inp_data_i (inp_data_i),
    .inp_valid_i(inp_valid_i),
    .inp_ready_o(inp_ready_o),
    .oup_data_o (oup_data_o),
    .oup_valid_o(oup_valid_o),
    .oup_ready_i(oup_ready_i),
    .rsp_done_i (rsp_done_i),
    .outst_o    (outst_o),
    .limit_o    (limit_o),
    .err_o      (err_o)
  );

  always #5 clk_i = ~clk_i;

  int         total = 0;
  int         bad   = 0;
  int         cyc   = 0;
  logic       ihs, ohs;
  logic [7:0] exp_q [$];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // One clock: drive at negedge, sample shortly after, scoreboard the handshakes.
  task automatic drive_cycle(input logic v, input logic [7:0] d, input logic rdy, input logic done);
    @(negedge clk_i);
    inp_valid_i = v;
    inp_data_i  = d;
    oup_ready_i = rdy;
    rsp_done_i  = done;
    #1;
    ihs = v & inp_ready_o;
    ohs = oup_valid_o & rdy;
    if (ohs) begin
      if (exp_q.size() == 0) check_eq("spurious_out", 32'(oup_data_o), 32'hFFFF_FFFF);
      else check_eq("out_order", 32'(oup_data_o), 32'(exp_q.pop_front()));
    end
    if (ihs) exp_q.push_back(d);
    cyc++;
  endtask

  task automatic idle();
    drive_cycle(1'b0, 8'h00, 1'b1, 1'b0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int         sent, outs, acc, rcvd, c, max_outst;
    logic       rsp_pend;
    int         acc_t [$];
    int         t0;

    rst_i = 1'b1;
    inp_valid_i = 1'b1;
    inp_data_i  = 8'hAA;
    oup_ready_i = 1'b0;
    rsp_done_i  = 1'b0;

    // Reset with upstream valid held high
    repeat (2) @(negedge clk_i);
    #1;
    check_eq("rst_valid", 32'(oup_valid_o), 32'd0);
    check_eq("rst_outst", 32'(outst_o), 32'd0);
    check_eq("rst_err", 32'(err_o), 32'd0);
    check_eq("rst_limit", 32'(limit_o), 32'd0);
    rst_i = 1'b0;
    inp_valid_i = 1'b0;
    @(negedge clk_i);
    #1;
    check_eq("rel_ready", 32'(inp_ready_o), 32'd1);
    check_eq("rel_valid", 32'(oup_valid_o), 32'd0);

    // Streaming 0x10..0x1F, completion one cycle after each issue
    sent = 0; rcvd = 0; c = 0; max_outst = 0; rsp_pend = 1'b0;
    while (rcvd < 16 && c < 60) begin
      t0 = cyc;
      drive_cycle(sent < 16, 8'(8'h10 + sent), 1'b1, rsp_pend);
      if (int'(outst_o) > max_outst) max_outst = int'(outst_o);
      if (ohs) begin
        check_eq("stream_latency", 32'(t0 - acc_t.pop_front()), 32'd1);
        rcvd++;
      end
      if (ihs) begin
        acc_t.push_back(t0);
        sent++;
      end
      rsp_pend = ohs;
      c++;
    end
    check_eq("stream_count", 32'(rcvd), 32'd16);
    check_eq("stream_max_outst_le2", 32'(max_outst <= 2), 32'd1);
    if (rsp_pend) drive_cycle(1'b0, 8'h00, 1'b1, 1'b1);
    idle();
    check_eq("stream_drained", 32'(outst_o), 32'd0);

    // Limit: six beats offered, no completions
    sent = 0; outs = 0;
    for (int i = 0; i < 10; i++) begin
      drive_cycle(sent < 6, 8'(8'h30 + sent), 1'b1, 1'b0);
      if (ihs) sent++;
      if (ohs) outs++;
    end
    check_eq("lim_issued", 32'(outs), 32'd4);
    check_eq("lim_outst", 32'(outst_o), 32'd4);
    check_eq("lim_limit", 32'(limit_o), 32'd1);
    check_eq("lim_ready", 32'(inp_ready_o), 32'd0);
    drive_cycle(1'b1, 8'h34, 1'b1, 1'b1);
    check_eq("lim_blocked_on_pulse", 32'(ihs), 32'd0);
    drive_cycle(1'b1, 8'h34, 1'b1, 1'b0);
    check_eq("lim_credit_accept", 32'(ihs), 32'd1);
    drive_cycle(1'b0, 8'h00, 1'b1, 1'b0);
    check_eq("lim_fifth_issued", 32'(ohs), 32'd1);
    idle();
    check_eq("lim_outst_again", 32'(outst_o), 32'd4);
    repeat (4) drive_cycle(1'b0, 8'h00, 1'b1, 1'b1);
    idle();
    check_eq("lim_drained", 32'(outst_o), 32'd0);
    check_eq("lim_no_err", 32'(err_o), 32'd0);

    // Backpressure: three beats against a stalled output
    sent = 0; acc = 0;
    for (int i = 0; i < 4; i++) begin
      drive_cycle(sent < 3, 8'(8'h40 + sent), 1'b0, 1'b0);
      if (ihs) begin sent++; acc++; end
    end
    check_eq("bp_accepted", 32'(acc), 32'd2);
    check_eq("bp_ready", 32'(inp_ready_o), 32'd0);
    check_eq("bp_valid", 32'(oup_valid_o), 32'd1);
    check_eq("bp_head", 32'(oup_data_o), 32'h40);
    outs = 0;
    for (int i = 0; i < 8 && outs < 3; i++) begin
      drive_cycle(sent < 3, 8'(8'h40 + sent), 1'b1, 1'b0);
      if (ihs) sent++;
      if (ohs) outs++;
    end
    check_eq("bp_outs", 32'(outs), 32'd3);
    idle();
    check_eq("bp_outst", 32'(outst_o), 32'd3);
    drive_cycle(1'b0, 8'h00, 1'b1, 1'b1);
    idle();
    check_eq("sim_pre_outst", 32'(outst_o), 32'd2);

    // Simultaneous issue and retire
    drive_cycle(1'b1, 8'h50, 1'b1, 1'b0);
    check_eq("sim_accept", 32'(ihs), 32'd1);
    drive_cycle(1'b0, 8'h00, 1'b1, 1'b1);
    check_eq("sim_out_hs", 32'(ohs), 32'd1);
    idle();
    check_eq("sim_outst_held", 32'(outst_o), 32'd2);
    repeat (2) drive_cycle(1'b0, 8'h00, 1'b1, 1'b1);
    idle();
    check_eq("sim_drained", 32'(outst_o), 32'd0);
    check_eq("sim_no_err", 32'(err_o), 32'd0);

    // Underflow: sticky error until reset
    drive_cycle(1'b0, 8'h00, 1'b1, 1'b1);
    idle();
    check_eq("uf_err", 32'(err_o), 32'd1);
    check_eq("uf_outst", 32'(outst_o), 32'd0);
    repeat (3) idle();
    check_eq("uf_err_sticky", 32'(err_o), 32'd1);
    rst_i = 1'b1;
    idle();
    idle();
    rst_i = 1'b0;
    check_eq("uf_err_cleared", 32'(err_o), 32'd0);
    check_eq("uf_ready_after_rst", 32'(inp_ready_o), 32'd1);

    check_eq("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
